bnn_layer_seq: RTL and testbench

//  Sequences one full inference through the 6-lane conv/relu/maxpool engine.
//  Per pass it bit-serially loads six 25-bit kernels from weight ROM, runs the

---
 rtl/bnn_layer_seq_if.sv | 46 ++++
 rtl/bnn_layer_seq.sv | 218 +++++++++++++++++++++
 tb/tb_bnn_layer_seq.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bnn_layer_seq_if.sv
// Bundle of the sequencer's control, weight-ROM, pixel-feed and result signals.
//   master : the sequencer (drives strobes, addresses, engine controls, status)
//   slave  : the environment (host go/abort, weight ROM, conv engine)
// Handshakes:
//   - Weight ROM: w_rd is a read request with no backpressure; w_bit carries the
//     addressed bit on the cycle after w_rd.
//   - Pixel feed: a pixel moves on exactly the cycles where pix_rd is high.
//     pix_rd = din_ready (engine ready) AND a pixel still pending in this pass
//     (sequencer valid); pix_addr names the pixel moved on that cycle.
//   - Results: out_we marks a cycle where all six lanes present a pooled output.
interface bnn_layer_seq_if #(
  parameter int AW = 12,
  parameter int PW = 10
);
  logic          go;
  logic          abort;
  logic          w_rd;
  logic [AW-1:0] w_addr;
  logic          w_bit;
  logic [5:0]    weight_en;
  logic          weight;
  logic          start;
  logic          state;
  logic          din_ready;
  logic          pix_rd;
  logic [PW-1:0] pix_addr;
  logic [5:0]    ovalid;
  logic [5:0]    done;
  logic          out_we;
  logic [15:0]   out_cnt;
  logic          busy;
  logic          finished;
  logic          err;

  modport master (
    input  go, abort, w_bit, din_ready, ovalid, done,
    output w_rd, w_addr, weight_en, weight, start, state,
           pix_rd, pix_addr, out_we, out_cnt, busy, finished, err
  );

  modport slave (
    output go, abort, w_bit, din_ready, ovalid, done,
    input  w_rd, w_addr, weight_en, weight, start, state,
           pix_rd, pix_addr, out_we, out_cnt, busy, finished, err
  );
endinterface

// File: rtl/bnn_layer_seq.sv
// Sequences one inference through the 6-lane conv/relu/maxpool engine:
// layer 0 (one pass over L0_PIX pixels), then L1_PASSES layer-1 passes over
// L1_PIX pixels. Each pass serially loads six KBITS-bit kernels from the weight
// ROM, runs the engine while feeding pixels, counts pooled results, and then
// idles GAP cycles with start low.
// Ports:
//   clk         clock
//   rstn        asynchronous active-low reset
//   bus         bnn_layer_seq_if.master (go/abort, ROM, engine, status)
//   dbg_state_o current FSM state (IDLE=0 LOAD=1 RUN=2 GAPW=3 FIN=4 ERR=5)
module bnn_layer_seq #(
  parameter int KBITS     = 25,
  parameter int AW        = 12,
  parameter int PW        = 10,
  parameter int L0_PIX    = 784,
  parameter int L1_PIX    = 144,
  parameter int L1_PASSES = 2,
  parameter int GAP       = 4,
  parameter int TIMEOUT   = 4095
) (
  input  logic                   clk,
  input  logic                   rstn,
  bnn_layer_seq_if.master        bus,
  output logic [2:0]             dbg_state_o
);

  localparam int NLOAD = 6 * KBITS;
  localparam int IW    = $clog2(NLOAD + 1);
  localparam int BW    = $clog2(KBITS);
  localparam int PSW   = $clog2(L1_PASSES + 1);
  localparam int GW    = $clog2(GAP + 1);
  localparam int RW    = $clog2(TIMEOUT + 1);

  localparam logic [IW-1:0]  I_LAST  = IW'(NLOAD - 1);
  localparam logic [IW-1:0]  I_DRAIN = IW'(NLOAD);
  localparam logic [BW-1:0]  B_LAST  = BW'(KBITS - 1);
  localparam logic [PSW-1:0] P_LAST  = PSW'(L1_PASSES);
  localparam logic [GW-1:0]  G_LAST  = GW'(GAP - 1);
  localparam logic [RW-1:0]  R_MAX   = RW'(TIMEOUT);
  localparam logic [PW-1:0]  L0_N    = PW'(L0_PIX);
  localparam logic [PW-1:0]  L1_N    = PW'(L1_PIX);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_GAPW = 3'd3,
    S_FIN  = 3'd4,
    S_ERR  = 3'd5
  } fsm_t;

  fsm_t           fsm_q;
  logic [PSW-1:0] p_q;
  logic [IW-1:0]  i_q;
  logic [2:0]     lane_q;
  logic [BW-1:0]  bit_q;
  logic [GW-1:0]  gap_q;
  logic [RW-1:0]  run_cnt_q;
  logic [PW-1:0]  pix_cnt_q;
  logic           w_rd_q;
  logic [AW-1:0]  w_addr_q;
  logic [5:0]     weight_en_q;
  logic           start_q;
  logic           state_q;
  logic [15:0]    out_cnt_q;
  logic           finished_q;
  logic           err_q;

  logic           in_run;
  logic [PW-1:0]  npix;
  logic [5:0]     lane_oh;
  logic           pix_rd_w;
  logic           out_we_w;

  assign in_run  = (fsm_q == S_RUN);
  assign npix    = (p_q == '0) ? L0_N : L1_N;
  assign lane_oh = 6'b000001 << lane_q;

  // Pixel reads and result writes answer same-cycle engine inputs, so they are
  // decoded from registered state rather than registered themselves.
  assign pix_rd_w = in_run & bus.din_ready & (pix_cnt_q < npix);
  assign out_we_w = in_run & (bus.ovalid == 6'h3F);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fsm_q       <= S_IDLE;
      p_q         <= '0;
      i_q         <= '0;
      lane_q      <= '0;
      bit_q       <= '0;
      gap_q       <= '0;
      run_cnt_q   <= '0;
      pix_cnt_q   <= '0;
      w_rd_q      <= 1'b0;
      w_addr_q    <= '0;
      weight_en_q <= '0;
      start_q     <= 1'b0;
      state_q     <= 1'b0;
      out_cnt_q   <= '0;
      finished_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      finished_q  <= 1'b0;
      // The ROM answers one cycle after the read, so the lane select trails w_rd.
      weight_en_q <= w_rd_q ? lane_oh : 6'b0;

      if (bus.abort) begin
        fsm_q       <= S_IDLE;
        p_q         <= '0;
        w_rd_q      <= 1'b0;
        weight_en_q <= '0;
        start_q     <= 1'b0;
        state_q     <= 1'b0;
      end else begin
        case (fsm_q)
          S_IDLE, S_ERR: begin
            if (bus.go) begin
              fsm_q     <= S_LOAD;
              err_q     <= 1'b0;
              p_q       <= '0;
              i_q       <= '0;
              lane_q    <= '0;
              bit_q     <= '0;
              w_rd_q    <= 1'b1;
              w_addr_q  <= '0;
              out_cnt_q <= '0;
              state_q   <= 1'b0;
            end
          end

          S_LOAD: begin
            if (i_q == I_DRAIN) begin
              fsm_q     <= S_RUN;
              start_q   <= 1'b1;
              run_cnt_q <= '0;
              pix_cnt_q <= '0;
            end else begin
              i_q <= i_q + 1'b1;
              // The address stops on the last bit so the next pass can start
              // one past it without a separate base register.
              if (i_q == I_LAST) w_rd_q <= 1'b0;
              else               w_addr_q <= w_addr_q + 1'b1;
              if (bit_q == B_LAST) begin
                bit_q  <= '0;
                lane_q <= lane_q + 1'b1;
              end else begin
                bit_q <= bit_q + 1'b1;
              end
            end
          end

          S_RUN: begin
            if (pix_rd_w) pix_cnt_q <= pix_cnt_q + 1'b1;
            // A write seen together with done still counts.
            if (out_we_w && out_cnt_q != 16'hFFFF) out_cnt_q <= out_cnt_q + 1'b1;
            if (bus.done == 6'h3F) begin
              fsm_q   <= S_GAPW;
              start_q <= 1'b0;
              gap_q   <= '0;
            end else if (run_cnt_q == R_MAX) begin
              fsm_q   <= S_ERR;
              start_q <= 1'b0;
              state_q <= 1'b0;
              err_q   <= 1'b1;
            end else begin
              run_cnt_q <= run_cnt_q + 1'b1;
            end
          end

          S_GAPW: begin
            if (gap_q == G_LAST) begin
              if (p_q == P_LAST) begin
                fsm_q      <= S_FIN;
                finished_q <= 1'b1;
                state_q    <= 1'b0;
              end else begin
                fsm_q     <= S_LOAD;
                p_q       <= p_q + 1'b1;
                i_q       <= '0;
                lane_q    <= '0;
                bit_q     <= '0;
                w_rd_q    <= 1'b1;
                w_addr_q  <= w_addr_q + 1'b1;
                out_cnt_q <= '0;
                state_q   <= 1'b1;
              end
            end else begin
              gap_q <= gap_q + 1'b1;
            end
          end

          S_FIN: begin
            fsm_q <= S_IDLE;
            p_q   <= '0;
          end

          default: fsm_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.w_rd      = w_rd_q;
  assign bus.w_addr    = w_addr_q;
  assign bus.weight_en = weight_en_q;
  assign bus.weight    = (|weight_en_q) & bus.w_bit;
  assign bus.start     = start_q;
  assign bus.state     = state_q;
  assign bus.pix_rd    = pix_rd_w;
  assign bus.pix_addr  = pix_cnt_q;
  assign bus.out_we    = out_we_w;
  assign bus.out_cnt   = out_cnt_q;
  assign bus.busy      = (fsm_q != S_IDLE) && (fsm_q != S_ERR);
  assign bus.finished  = finished_q;
  assign bus.err       = err_q;
  assign dbg_state_o   = fsm_q;

endmodule

// File: tb/tb_bnn_layer_seq.sv
module tb_bnn_layer_seq;
  localparam int AW = 12;
  localparam int PW = 10;

  logic       clk;
  logic       rstn;
  logic [2:0] dbg_state;
  int         n_pass;
  int         n_total;
  logic [PW-1:0] exp_q[$];

  typedef struct {
    logic        din;
    logic [5:0]  ovalid;
    logic [5:0]  done;
    logic        pix_rd;
    logic [9:0]  pix_addr;
    logic        we;
    logic [15:0] cnt;
    logic [2:0]  st;
  } vec_t;

  vec_t vec[7];

  bnn_layer_seq_if #(.AW(AW), .PW(PW)) bif ();

  bnn_layer_seq #(
    .KBITS(25), .AW(AW), .PW(PW), .L0_PIX(784), .L1_PIX(144),
    .L1_PASSES(2), .GAP(4), .TIMEOUT(4095)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .bus        (bif),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Weight ROM: bit k holds k[0], data one cycle after the read.
  always @(posedge clk) bif.w_bit <= bif.w_rd ? bif.w_addr[0] : 1'b0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_go();
    bif.go = 1'b1;
    tick();
    bif.go = 1'b0;
  endtask

  task automatic wait_start(output int n);
    n = 0;
    while (!bif.start && n < 300) begin
      tick();
      n++;
    end
  endtask

  task automatic gap_count(output int n);
    n = 0;
    while (!bif.w_rd && !bif.finished && n < 20) begin
      chk("gap_start_low", bif.start, 0);
      n++;
      tick();
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [63:0] outs();
    return {11'd0, bif.w_rd, bif.w_addr, bif.weight_en, bif.weight, bif.start,
            bif.state, bif.pix_rd, bif.pix_addr, bif.out_we, bif.out_cnt,
            bif.busy, bif.finished, bif.err};
  endfunction

  // ---------------- test ----------------
  initial begin
    int n;
    int pix_seen;
    int fin_cnt;
    logic [5:0] ov;
    logic [5:0] en_e;

    // din, ovalid, done, exp pix_rd, exp pix_addr, exp out_we, exp out_cnt after, exp fsm after
    vec[0] = '{1'b1, 6'h3F, 6'h00, 1'b1, 10'd0, 1'b1, 16'd1, 3'd2};
    vec[1] = '{1'b0, 6'h3F, 6'h00, 1'b0, 10'd1, 1'b1, 16'd2, 3'd2};
    vec[2] = '{1'b1, 6'h1F, 6'h00, 1'b1, 10'd1, 1'b0, 16'd2, 3'd2};
    vec[3] = '{1'b1, 6'h00, 6'h00, 1'b1, 10'd2, 1'b0, 16'd2, 3'd2};
    vec[4] = '{1'b0, 6'h3E, 6'h1F, 1'b0, 10'd3, 1'b0, 16'd2, 3'd2};
    vec[5] = '{1'b1, 6'h3F, 6'h3E, 1'b1, 10'd3, 1'b1, 16'd3, 3'd2};
    vec[6] = '{1'b1, 6'h3F, 6'h3F, 1'b1, 10'd4, 1'b1, 16'd4, 3'd3};

    n_pass = 0;
    n_total = 0;
    rstn = 1'b0;
    bif.go = 1'b0;
    bif.abort = 1'b0;
    bif.din_ready = 1'b0;
    bif.ovalid = 6'h00;
    bif.done = 6'h00;

    repeat (3) @(posedge clk);
    #2;
    chk("reset_outs", outs(), 0);
    chk("reset_fsm", dbg_state, 0);
    @(negedge clk) rstn = 1'b1;
    tick();
    chk("idle_outs", outs(), 0);

    // ---- pass 0: kernel load ----
    pulse_go();
    chk("load0_busy", bif.busy, 1);
    chk("load0_state", bif.state, 0);
    for (int c = 0; c <= 150; c++) begin
      en_e = (c >= 1) ? 6'(1 << ((c - 1) / 25)) : 6'd0;
      chk("load0_w_rd", bif.w_rd, (c < 150));
      if (c < 150) chk("load0_w_addr", bif.w_addr, c);
      chk("load0_weight_en", bif.weight_en, en_e);
      if (c >= 1) chk("load0_weight", bif.weight, (c - 1) % 2);
      tick();
    end

    // ---- pass 0: run ----
    chk("run0_start", bif.start, 1);
    chk("run0_weight_en_idle", bif.weight_en, 0);
    for (int i = 0; i < 784; i++) exp_q.push_back(PW'(i));
    pix_seen = 0;
    for (int rc = 0; rc < 800; rc++) begin
      ov = (rc < 145) ? ((rc == 50) ? 6'h1F : 6'h3F) : 6'h00;
      bif.din_ready = 1'b1;
      bif.ovalid = ov;
      bif.done = 6'h00;
      #1;
      if (rc < 146) chk("run0_out_we", bif.out_we, (ov == 6'h3F));
      if (bif.pix_rd) begin
        pix_seen++;
        if (exp_q.size() == 0) chk("run0_pix_rd_after_npix", bif.pix_rd, 0);
        else chk("run0_pix_addr", bif.pix_addr, exp_q.pop_front());
      end
      tick();
    end
    chk("run0_pix_count", pix_seen, 784);
    chk("run0_queue_left", exp_q.size(), 0);
    chk("run0_out_cnt", bif.out_cnt, 144);
    chk("run0_fsm", dbg_state, 2);

    bif.ovalid = 6'h00;
    bif.done = 6'h3F;
    #1;
    chk("run0_no_pix_rd_done", bif.pix_rd, 0);
    tick();
    bif.done = 6'h00;
    bif.din_ready = 1'b0;
    chk("gapw0_fsm", dbg_state, 3);
    chk("gapw0_start", bif.start, 0);
    gap_count(n);
    chk("gap0_len", n, 4);

    // ---- pass 1 ----
    chk("pass1_w_addr", bif.w_addr, 150);
    chk("pass1_state", bif.state, 1);
    chk("pass1_out_cnt_clear", bif.out_cnt, 0);
    wait_start(n);
    chk("pass1_load_len", n, 151);
    for (int v = 0; v < 7; v++) begin
      bif.din_ready = vec[v].din;
      bif.ovalid = vec[v].ovalid;
      bif.done = vec[v].done;
      #1;
      chk($sformatf("vec%0d_pix_rd", v), bif.pix_rd, vec[v].pix_rd);
      chk($sformatf("vec%0d_pix_addr", v), bif.pix_addr, vec[v].pix_addr);
      chk($sformatf("vec%0d_out_we", v), bif.out_we, vec[v].we);
      tick();
      chk($sformatf("vec%0d_out_cnt", v), bif.out_cnt, vec[v].cnt);
      chk($sformatf("vec%0d_fsm", v), dbg_state, vec[v].st);
    end
    bif.din_ready = 1'b0;
    bif.ovalid = 6'h00;
    bif.done = 6'h00;
    chk("pass1_state_in_gap", bif.state, 1);
    gap_count(n);
    chk("gap1_len", n, 4);

    // ---- pass 2 ----
    chk("pass2_w_addr", bif.w_addr, 300);
    chk("pass2_state", bif.state, 1);
    wait_start(n);
    chk("pass2_load_len", n, 151);
    bif.done = 6'h3F;
    tick();
    bif.done = 6'h00;
    fin_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      if (bif.finished) fin_cnt++;
      tick();
    end
    chk("fin_pulses", fin_cnt, 1);
    chk("fin_fsm_idle", dbg_state, 0);
    chk("fin_busy", bif.busy, 0);
    chk("fin_err", bif.err, 0);

    // ---- timeout ----
    pulse_go();
    wait_start(n);
    chk("t_load_len", n, 151);
    n = 0;
    while (bif.start && n < 5000) begin
      n++;
      tick();
    end
    chk("timeout_run_cycles", n, 4096);
    chk("timeout_err", bif.err, 1);
    chk("timeout_fsm", dbg_state, 5);
    chk("timeout_busy", bif.busy, 0);
    pulse_go();
    chk("go_clears_err", bif.err, 0);
    chk("restart_fsm", dbg_state, 1);
    chk("restart_w_addr", bif.w_addr, 0);
    chk("restart_w_rd", bif.w_rd, 1);
    chk("restart_state", bif.state, 0);

    // ---- go while busy, abort mid-load ----
    repeat (10) tick();
    chk("load_addr_pre_go", bif.w_addr, 10);
    pulse_go();
    chk("go_ignored_busy", bif.w_addr, 11);
    bif.abort = 1'b1;
    tick();
    bif.abort = 1'b0;
    chk("abort_fsm", dbg_state, 0);
    chk("abort_w_rd", bif.w_rd, 0);
    chk("abort_weight_en", bif.weight_en, 0);
    chk("abort_busy", bif.busy, 0);
    bif.abort = 1'b1;
    bif.go = 1'b1;
    tick();
    bif.abort = 1'b0;
    bif.go = 1'b0;
    chk("abort_over_go_fsm", dbg_state, 0);
    chk("abort_over_go_w_rd", bif.w_rd, 0);

    // ---- reset mid-run ----
    pulse_go();
    wait_start(n);
    bif.din_ready = 1'b1;
    bif.ovalid = 6'h3F;
    repeat (10) tick();
    chk("pre_reset_out_cnt", bif.out_cnt, 10);
    rstn = 1'b0;
    #1;
    chk("reset_mid_run_outs", outs(), 0);
    chk("reset_mid_run_fsm", dbg_state, 0);
    tick();
    chk("reset_held_outs", outs(), 0);
    @(negedge clk) rstn = 1'b1;
    tick();
    chk("post_reset_outs", outs(), 0);
    chk("post_reset_fsm", dbg_state, 0);
    bif.din_ready = 1'b0;
    bif.ovalid = 6'h00;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
